fll_tune_ctrl: RTL and testbench

Closed-loop tuning controller for the FLL frequency comparator. It consumes each signed period-difference result (`delta`) that the FLL produces and steers the local generator's frequency word through coarse and fine acquisition until lock. It then tracks lock quality and reports loss of lock. It sits between the FLL block and the NCO/generator that drives `signal_gen`, closing the loop that the FLL only measures.

---
 rtl/fll_ctrl_pkg.sv | 26 ++
 rtl/fw_sat_add.sv | 39 +++
 rtl/fll_tune_ctrl.sv | 184 ++++++++++++++++++
 tb/tb_fll_tune_ctrl.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/fll_ctrl_pkg.sv
// Shared types and helpers for the FLL tuning controller.
package fll_ctrl_pkg;

  // Controller states, in debug-encoding order.
  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_COARSE = 3'd1,
    ST_FINE   = 3'd2,
    ST_LOCKED = 3'd3
  } fll_ctrl_st_t;

  // A sample whose magnitude is at or below this counts as "good".
  localparam logic [31:0] FLL_FINE_TH = 32'd1;

  // Absolute value as an unsigned 32-bit result; -2^31 maps to 2^31,
  // so the most negative input is always the largest magnitude.
  function automatic logic [31:0] abs32(input logic signed [31:0] i_d);
    logic [31:0] r_mag;
    r_mag = i_d;
    if (i_d[31]) begin
      r_mag = ~r_mag + 32'd1;
    end
    return r_mag;
  endfunction

endpackage

// File: rtl/fw_sat_add.sv
// Frequency-word adder: adds a signed increment to an unsigned word and
// clamps the result into [F_MIN, F_MAX]; flags whether the word moved.
module fw_sat_add #(
  parameter int             FW    = 32,
  parameter logic [FW-1:0]  F_MIN = '0,
  parameter logic [FW-1:0]  F_MAX = '1
) (
  input  logic [FW-1:0]        i_fw,
  input  logic signed [FW+33:0] i_inc,
  output logic [FW-1:0]        o_fw,
  output logic                 o_changed
);

  localparam int SW = FW + 34;

  logic signed [SW-1:0] w_sum;
  logic signed [SW-1:0] w_min;
  logic signed [SW-1:0] w_max;
  logic [FW-1:0]        w_res;

  // The wide signed sum can never overflow, so clamping is a plain compare.
  assign w_sum = $signed({34'd0, i_fw}) + i_inc;
  assign w_min = $signed({34'd0, F_MIN});
  assign w_max = $signed({34'd0, F_MAX});

  // Clamp the sum into the legal frequency-word range.
  always_comb begin
    w_res = w_sum[FW-1:0];
    if (w_sum < w_min) begin
      w_res = F_MIN;
    end else if (w_sum > w_max) begin
      w_res = F_MAX;
    end
  end

  assign o_fw      = w_res;
  assign o_changed = (w_res != i_fw);

endmodule

// File: rtl/fll_tune_ctrl.sv
// Closed-loop tuning controller: steers the NCO frequency word from FLL
// period-difference samples through coarse and fine acquisition to lock,
// then watches lock quality and reports loss of lock.
module fll_tune_ctrl
  import fll_ctrl_pkg::*;
#(
  parameter int            FW        = 32,
  parameter logic [FW-1:0] F_INIT    = 32'h0100_0000,
  parameter logic [FW-1:0] F_MIN     = '0,
  parameter logic [FW-1:0] F_MAX     = 32'hFFFF_FFFF,
  parameter int            GAIN_SH   = 4,
  parameter int            COARSE_TH = 8,
  parameter int            LOCK_CNT  = 8,
  parameter int            LOSS_CNT  = 4
) (
  input  logic               clk,
  input  logic               reset_l,
  input  logic               en,
  input  logic signed [31:0] delta,
  input  logic               delta_vld,
  input  logic               blok,
  output logic [FW-1:0]      fw,
  output logic               fw_vld,
  output logic [2:0]         st,
  output logic               locked,
  output logic               lost
);

  localparam int SW = FW + 34;
  localparam int GW = $clog2(LOCK_CNT + 1);
  localparam int BW = $clog2(LOSS_CNT + 1);

  localparam logic [GW-1:0] GOOD_TERM   = GW'(LOCK_CNT);
  localparam logic [BW-1:0] BAD_TERM    = BW'(LOSS_CNT);
  localparam logic [31:0]   COARSE_TH_W = 32'(COARSE_TH);

  fll_ctrl_st_t r_st;
  fll_ctrl_st_t w_nxt_st;
  logic [FW-1:0] r_fw;
  logic          r_fw_vld;
  logic          r_locked;
  logic          r_lost;
  logic [GW-1:0] r_good;
  logic [GW-1:0] w_nxt_good;
  logic [GW-1:0] w_good_inc;
  logic [BW-1:0] r_bad;
  logic [BW-1:0] w_nxt_bad;
  logic [BW-1:0] w_bad_inc;

  logic                 w_acc;
  logic [31:0]          w_abs;
  logic                 w_is_good;
  logic                 w_in_fine_range;
  logic signed [SW-1:0] w_coarse_inc;
  logic signed [SW-1:0] w_sign_inc;
  logic signed [SW-1:0] w_inc;
  logic                 w_upd;
  logic                 w_lost;
  logic [FW-1:0]        w_sum_fw;
  logic                 w_changed;

  // A sample only counts when qualified, not held off, and the loop is on.
  assign w_acc           = delta_vld & ~blok & en;
  assign w_abs           = abs32(delta);
  assign w_is_good       = (w_abs <= FLL_FINE_TH);
  assign w_in_fine_range = (w_abs <= COARSE_TH_W);

  // Coarse step is the gained delta; fine step is just its sign.
  assign w_coarse_inc = {{(SW-32){delta[31]}}, delta} <<< GAIN_SH;
  assign w_sign_inc   = delta[31] ? {SW{1'b1}} :
                        ((delta != '0) ? SW'(1) : '0);

  // Counters stick at their terminal values rather than wrapping.
  assign w_good_inc = (r_good == GOOD_TERM) ? r_good : r_good + GW'(1);
  assign w_bad_inc  = (r_bad  == BAD_TERM)  ? r_bad  : r_bad  + BW'(1);

  fw_sat_add #(
    .FW    (FW),
    .F_MIN (F_MIN),
    .F_MAX (F_MAX)
  ) u_fw_sat_add (
    .i_fw      (r_fw),
    .i_inc     (w_inc),
    .o_fw      (w_sum_fw),
    .o_changed (w_changed)
  );

  // Next-state, counter and correction decisions for the current cycle.
  always_comb begin
    w_nxt_st   = r_st;
    w_nxt_good = r_good;
    w_nxt_bad  = r_bad;
    w_upd      = 1'b0;
    w_inc      = '0;
    w_lost     = 1'b0;
    if (!en) begin
      w_nxt_st = ST_IDLE;
    end else begin
      unique case (r_st)
        ST_IDLE: begin
          w_nxt_st   = ST_COARSE;
          w_nxt_good = '0;
          w_nxt_bad  = '0;
        end
        ST_COARSE: begin
          if (w_acc) begin
            w_upd = 1'b1;
            w_inc = w_coarse_inc;
            if (w_in_fine_range) begin
              w_nxt_st   = ST_FINE;
              w_nxt_good = '0;
            end
          end
        end
        ST_FINE: begin
          if (w_acc) begin
            w_upd = 1'b1;
            w_inc = w_sign_inc;
            if (w_is_good) begin
              w_nxt_good = w_good_inc;
              if (w_good_inc == GOOD_TERM) begin
                w_nxt_st  = ST_LOCKED;
                w_nxt_bad = '0;
              end
            end else if (w_in_fine_range) begin
              w_nxt_good = '0;
            end else begin
              w_nxt_st = ST_COARSE;
            end
          end
        end
        ST_LOCKED: begin
          if (w_acc) begin
            w_upd = 1'b1;
            w_inc = w_sign_inc;
            if (w_is_good) begin
              w_nxt_bad = '0;
            end else begin
              w_nxt_bad = w_bad_inc;
              if (w_bad_inc == BAD_TERM) begin
                w_nxt_st   = ST_COARSE;
                w_nxt_good = '0;
                w_lost     = 1'b1;
              end
            end
          end
        end
        default: begin
          w_nxt_st = ST_IDLE;
        end
      endcase
    end
  end

  // State, counters and registered outputs.
  always_ff @(posedge clk or negedge reset_l) begin
    if (!reset_l) begin
      r_st     <= ST_IDLE;
      r_fw     <= F_INIT;
      r_fw_vld <= 1'b0;
      r_locked <= 1'b0;
      r_lost   <= 1'b0;
      r_good   <= '0;
      r_bad    <= '0;
    end else begin
      r_st     <= w_nxt_st;
      r_good   <= w_nxt_good;
      r_bad    <= w_nxt_bad;
      r_fw_vld <= w_upd & w_changed;
      r_locked <= (w_nxt_st == ST_LOCKED);
      r_lost   <= w_lost;
      if (w_upd) begin
        r_fw <= w_sum_fw;
      end
    end
  end

  assign fw     = r_fw;
  assign fw_vld = r_fw_vld;
  assign st     = r_st;
  assign locked = r_locked;
  assign lost   = r_lost;

endmodule

// File: tb/tb_fll_tune_ctrl.sv
// Bench for fll_tune_ctrl: directed acquisition/lock/loss/saturation
// scenarios followed by random traffic, all compared cycle by cycle with
// an arithmetic reference model of the tuning rules.
module tb_fll_tune_ctrl;

  localparam longint FMAX  = 64'h0000_0000_FFFF_FFFF;
  localparam longint FINIT = 64'h0000_0000_0100_0000;

  logic        clk = 1'b0;
  logic        reset_l;
  logic        en;
  logic [31:0] delta;
  logic        delta_vld;
  logic        blok;
  logic [31:0] fw;
  logic        fw_vld;
  logic [2:0]  st;
  logic        locked;
  logic        lost;

  int total = 0;
  int bad   = 0;

  // Reference model: state number 0..3, word as a plain integer.
  int     mSt;
  longint mFw;
  int     mGood;
  int     mBad;
  bit     mVld;
  bit     mLost;

  fll_tune_ctrl dut (
    .clk       (clk),
    .reset_l   (reset_l),
    .en        (en),
    .delta     (delta),
    .delta_vld (delta_vld),
    .blok      (blok),
    .fw        (fw),
    .fw_vld    (fw_vld),
    .st        (st),
    .locked    (locked),
    .lost      (lost)
  );

  // Free-running clock, rising edges at 5, 15, 25, ...
  always #5 clk = ~clk;

  // One comparison: count it and report any mismatch.
  task automatic checkOutput(input string tag, input longint obs, input longint exp);
    total++;
    if (obs != exp) begin
      bad++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic void modelReset();
    mSt = 0; mFw = FINIT; mGood = 0; mBad = 0; mVld = 0; mLost = 0;
  endfunction

  function automatic void applyFw(input longint inc);
    longint n;
    n = mFw + inc;
    if (n < 0) n = 0;
    if (n > FMAX) n = FMAX;
    mVld = (n != mFw);
    mFw  = n;
  endfunction

  // Advance the model by one clock using the inputs seen at that edge.
  function automatic void modelStep(input bit e, input bit v, input logic signed [31:0] d, input bit b);
    longint ld, a, sgn;
    bit acc;
    ld  = longint'(d);
    a   = (ld < 0) ? -ld : ld;
    sgn = (ld > 0) ? 1 : ((ld < 0) ? -1 : 0);
    acc = v && !b && e;
    mVld  = 0;
    mLost = 0;
    if (!e) begin
      mSt = 0;
    end else if (mSt == 0) begin
      mSt = 1; mGood = 0; mBad = 0;
    end else if (mSt == 1) begin
      if (acc) begin
        applyFw(ld * 16);
        if (a <= 8) begin mSt = 2; mGood = 0; end
      end
    end else if (mSt == 2) begin
      if (acc) begin
        applyFw(sgn);
        if (a <= 1) begin
          if (mGood < 8) mGood++;
          if (mGood == 8) begin mSt = 3; mBad = 0; end
        end else if (a <= 8) begin
          mGood = 0;
        end else begin
          mSt = 1;
        end
      end
    end else begin
      if (acc) begin
        applyFw(sgn);
        if (a <= 1) begin
          mBad = 0;
        end else begin
          if (mBad < 4) mBad++;
          if (mBad == 4) begin mSt = 1; mGood = 0; mLost = 1; end
        end
      end
    end
  endfunction

  task automatic compareAll();
    checkOutput("fw",     longint'(fw),     mFw);
    checkOutput("fw_vld", longint'(fw_vld), longint'(mVld));
    checkOutput("st",     longint'(st),     longint'(mSt));
    checkOutput("locked", longint'(locked), (mSt == 3) ? 1 : 0);
    checkOutput("lost",   longint'(lost),   longint'(mLost));
  endtask

  // Drive one cycle of inputs, clock it, then compare against the model.
  task automatic applyStimulus(input bit e, input bit v, input logic [31:0] d, input bit b);
    en = e; delta_vld = v; delta = d; blok = b;
    @(posedge clk);
    modelStep(e, v, d, b);
    #1;
    compareAll();
  endtask

  task automatic pulseReset();
    #2 reset_l = 1'b0;
    #1;
    modelReset();
    compareAll();
    checkOutput("rst_fw", longint'(fw), FINIT);
    checkOutput("rst_st", longint'(st), 0);
    #2 reset_l = 1'b1;
  endtask

  initial begin
    logic [31:0] rd;
    int sel;
    reset_l = 1'b0; en = 1'b0; delta = '0; delta_vld = 1'b0; blok = 1'b0;
    modelReset();
    #12;
    compareAll();
    checkOutput("reset_fw", longint'(fw), FINIT);
    reset_l = 1'b1;

    // Acquisition: coarse step, then into FINE.
    applyStimulus(1, 0, 32'd0, 0);
    checkOutput("to_coarse", longint'(st), 1);
    applyStimulus(1, 1, 32'd100, 0);
    checkOutput("coarse_fw", longint'(fw), 64'h0100_0640);
    checkOutput("coarse_vld", longint'(fw_vld), 1);
    applyStimulus(1, 1, 32'd5, 0);
    checkOutput("fine_fw", longint'(fw), 64'h0100_0690);
    checkOutput("to_fine", longint'(st), 2);

    // Eight good samples to lock.
    for (int i = 0; i < 8; i++) applyStimulus(1, 1, 32'd0, 0);
    checkOutput("to_locked", longint'(locked), 1);

    // Bad run interrupted by a good sample, then a full bad run.
    for (int i = 0; i < 3; i++) applyStimulus(1, 1, 32'd3, 0);
    checkOutput("no_loss", longint'(st), 3);
    applyStimulus(1, 1, 32'd0, 0);
    for (int i = 0; i < 4; i++) applyStimulus(1, 1, -32'sd3, 0);
    checkOutput("lost_pulse", longint'(lost), 1);
    checkOutput("lost_st", longint'(st), 1);
    checkOutput("lost_fw", longint'(fw), 64'h0100_068F);
    applyStimulus(1, 0, 32'd0, 0);
    checkOutput("lost_once", longint'(lost), 0);

    // Drive the word up to the top bound.
    applyStimulus(1, 1, 32'h7FFF_FFFF, 0);
    checkOutput("sat_hi", longint'(fw), FMAX);
    applyStimulus(1, 1, 32'hFFFF_FFFF, 0);
    for (int i = 0; i < 13; i++) applyStimulus(1, 1, 32'd5, 0);
    applyStimulus(1, 1, 32'd100, 0);
    checkOutput("near_max", longint'(fw), FMAX - 2);
    applyStimulus(1, 1, 32'd50, 0);
    checkOutput("clamp_fw", longint'(fw), FMAX);
    applyStimulus(1, 1, 32'd50, 0);
    checkOutput("clamp_novld", longint'(fw_vld), 0);

    // Hold window and enable drop.
    applyStimulus(1, 1, 32'd100, 1);
    checkOutput("blok_fw", longint'(fw), FMAX);
    applyStimulus(0, 1, 32'd100, 0);
    checkOutput("en_idle", longint'(st), 0);
    applyStimulus(0, 0, 32'd0, 0);

    // Reset in FINE with five good samples, then relock from scratch.
    applyStimulus(1, 0, 32'd0, 0);
    applyStimulus(1, 1, 32'd5, 0);
    for (int i = 0; i < 5; i++) applyStimulus(1, 1, 32'd0, 0);
    pulseReset();
    applyStimulus(1, 0, 32'd0, 0);
    applyStimulus(1, 1, 32'd5, 0);
    for (int i = 0; i < 7; i++) applyStimulus(1, 1, 32'd0, 0);
    checkOutput("relock_wait", longint'(st), 2);
    applyStimulus(1, 1, 32'd0, 0);
    checkOutput("relock", longint'(st), 3);

    // Random traffic, biased toward small deltas so all states are visited.
    for (int i = 0; i < 3000; i++) begin
      sel = int'($urandom_range(0, 99));
      if (sel < 50)      rd = 32'($signed(int'($urandom_range(0, 6)) - 3));
      else if (sel < 75) rd = 32'($signed(int'($urandom_range(0, 20)) - 10));
      else if (sel < 90) rd = $urandom;
      else if (sel < 95) rd = 32'h8000_0000;
      else               rd = 32'h7FFF_FFFF;
      applyStimulus($urandom_range(0, 99) < 97, $urandom_range(0, 99) < 70,
                    rd, $urandom_range(0, 99) < 10);
      if (i == 1500) pulseReset();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
